// File: rtl/image_roi_streamer.sv
// image_roi_streamer: reads a rectangular region of interest out of a row-major
// frame memory and streams it out one pixel per clock with valid/ready
// backpressure and sof/eol/eof framing. A 2-entry skid FIFO absorbs the
// one-cycle memory latency, so reads are only issued when a slot is guaranteed.
module image_roi_streamer #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_W    = $clog2(IMG_W * IMG_H),
    parameter int XW        = $clog2(IMG_W + 1),
    parameter int YW        = $clog2(IMG_H + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XW-1:0]        roiX,
    input  logic [YW-1:0]        roiY,
    input  logic [XW-1:0]        roiW,
    input  logic [YW-1:0]        roiH,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 readEnable,
    output logic [ADDR_W-1:0]    readAddr,
    input  logic [BIT_DEPTH-1:0] readData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [BIT_DEPTH-1:0] outData,
    output logic                 outSof,
    output logic                 outEol,
    output logic                 outEof
);

    typedef enum logic [2:0] {IDLE, CHECK, READ, DRAIN, FINISH} state_t;

    localparam logic [XW:0] W_LIMIT = (XW + 1)'(IMG_W);
    localparam logic [YW:0] H_LIMIT = (YW + 1)'(IMG_H);

    // Sums are one bit wider than the operands so an oversized ROI cannot wrap
    // around and look legal.
    function automatic logic roi_ok(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                    input logic [XW-1:0] w, input logic [YW-1:0] h);
        logic [XW:0] x_end;
        logic [YW:0] y_end;
        x_end = {1'b0, x} + {1'b0, w};
        y_end = {1'b0, y} + {1'b0, h};
        return (w != '0) && (h != '0) && (x_end <= W_LIMIT) && (y_end <= H_LIMIT);
    endfunction

    state_t                state;
    logic                  roi_good;
    logic [XW-1:0]         roi_x, roi_w;
    logic [YW-1:0]         roi_y, roi_h;
    logic [XW-1:0]         col;
    logic [YW-1:0]         row;
    logic [ADDR_W-1:0]     row_base;
    logic                  first_p0;
    logic                  col_last, row_last;
    logic                  issue, push, pop;
    logic [2:0]            occupancy;

    logic                  vld_p1;
    logic                  sof_p1, eol_p1, eof_p1;

    logic [1:0]            fifo_count;
    logic                  wr_ptr, rd_ptr;
    logic [BIT_DEPTH-1:0]  fifo_data [2];
    logic [2:0]            fifo_tag  [2];

    // ---- p0: address generation and read issue ----
    assign col_last  = (col == roi_w - XW'(1));
    assign row_last  = (row == roi_h - YW'(1));
    assign pop       = outValid && outReady;
    assign push      = vld_p1;
    assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1};
    assign issue     = (state == READ) && (occupancy < 3'd2 + {2'b00, pop});

    assign readEnable = issue;
    assign readAddr   = row_base + ADDR_W'(col);

    // Control FSM: latches the ROI check, walks col/row, sequences drain and done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            roi_good <= 1'b0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            first_p0 <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        roi_good <= roi_ok(roiX, roiY, roiW, roiH);
                        err      <= !roi_ok(roiX, roiY, roiW, roiH);
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (!roi_good) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        col      <= '0;
                        row      <= '0;
                        row_base <= ADDR_W'(roi_y) * ADDR_W'(IMG_W) + ADDR_W'(roi_x);
                        first_p0 <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        first_p0 <= 1'b0;
                        if (col_last) begin
                            col      <= '0;
                            row      <= row + YW'(1);
                            row_base <= row_base + ADDR_W'(IMG_W);
                            if (row_last) state <= DRAIN;
                        end else begin
                            col <= col + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_count == 2'd0 && !vld_p1) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ROI capture; only meaningful once a start is accepted, so no reset needed.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            roi_x <= roiX;
            roi_y <= roiY;
            roi_w <= roiW;
            roi_h <= roiH;
        end
    end

    // ---- p1: memory return cycle ----
    // Tracks the single outstanding read; clearing it on reset discards a return in flight.
    always_ff @(posedge clock) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= issue;
    end

    // Framing tags travel alongside the read they were computed for.
    always_ff @(posedge clock) begin
        if (issue) begin
            sof_p1 <= first_p0;
            eol_p1 <= col_last;
            eof_p1 <= col_last && row_last;
        end
    end

    // ---- p2: output FIFO ----
    // FIFO occupancy and pointers; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage: captures the returned pixel with its tags.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= readData;
            fifo_tag[wr_ptr]  <= {sof_p1, eol_p1, eof_p1};
        end
    end

    assign outValid = (fifo_count != 2'd0);
    assign outData  = fifo_data[rd_ptr];
    assign outSof   = fifo_tag[rd_ptr][2];
    assign outEol   = fifo_tag[rd_ptr][1];
    assign outEof   = fifo_tag[rd_ptr][0];

endmodule

// File: doc/image_roi_streamer.md
Name: image_roi_streamer

Overview:
- Parametrised successor to the frame-memory image reader.
- Reads a rectangular region of interest (ROI) out of a row-major frame memory and emits it as a pixel stream with valid/ready backpressure and sof/eol/eof framing.
- Sits between the frame buffer RAM and downstream VGA/Ethernet packetisers.
- Sustains 1 pixel/clock when the sink is always ready.

Parameters:
- BIT_DEPTH, 8, bits per pixel.
- IMG_W, 640, frame width in pixels.
- IMG_H, 480, frame height in pixels.
- ADDR_W, $clog2(IMG_W*IMG_H), memory address width.
- XW, $clog2(IMG_W+1), width of X/width fields.
- YW, $clog2(IMG_H+1), width of Y/height fields.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a readout; sampled only in IDLE.
- roiX  in  XW  ROI left column.
- roiY  in  YW  ROI top row.
- roiW  in  XW  ROI width.
- roiH  in  YW  ROI height.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse after the last pixel handshake.
- err  out  1  one-cycle pulse when the ROI is rejected.
- readEnable  out  1  memory read strobe.
- readAddr  out  ADDR_W  memory read address.
- readData  in  BIT_DEPTH  memory data, valid exactly 1 cycle after readEnable.
- outValid  out  1  stream valid.
- outReady  in  1  stream ready.
- outData  out  BIT_DEPTH  pixel.
- outSof  out  1  first pixel of the ROI.
- outEol  out  1  last pixel of each ROI row.
- outEof  out  1  last pixel of the ROI.

Behaviour:
- Clock domain: one clock, `clock`; `reset` is synchronous and active-high.
- Reset values:
  - State IDLE.
  - busy, done, err, readEnable, outValid = 0.
  - Output FIFO empty; in-flight count 0; readAddr = 0.
- States: IDLE, CHECK, READ, DRAIN, FINISH.
- IDLE:
  - start=1 latches roiX/Y/W/H → CHECK.
  - Inputs are ignored while busy.
- CHECK (1 cycle):
  - Reject if roiW==0, roiH==0, roiX+roiW>IMG_W or roiY+roiH>IMG_H; compute sums one bit wider to avoid wrap.
  - Reject → err=1 this cycle, no reads issued, → IDLE.
  - Accept → READ; init col=0, row=0, rowBase=roiY*IMG_W+roiX.
- READ (address generation):
  - readAddr = rowBase+col.
  - A read issues (readEnable=1) when fifoCount + inFlight − pop < 2, where pop = outValid & outReady in the same cycle.
  - On issue: col++. When col==roiW−1, col←0, row++, rowBase += IMG_W; no multiplier after CHECK.
  - After issuing the last pixel (row==roiH−1, col==roiW−1) → DRAIN.
- Read return:
  - readData is captured into a 2-entry FIFO at the end of the cycle after issue, with framing tags computed at issue time.
  - sof tag = first issue; eol tag = col==roiW−1; eof tag = eol on the last row.
- Stream output:
  - outValid = FIFO non-empty; outData/outSof/outEol/outEof come from the FIFO head.
  - Once asserted, outValid and the head contents stay stable until handshake.
  - Simultaneous push and pop are allowed; count is unchanged.
- DRAIN: waits until FIFO empty and inFlight==0 → FINISH.
- FINISH: done=1 for one cycle → IDLE.
  - A start sampled in that IDLE cycle or later begins the next readout; the earliest back-to-back start is the cycle after done.
- Latency (outReady=1):
  - start accepted cycle 0 → CHECK cycle 1 → first readEnable cycle 2 → readData cycle 3 → outValid cycle 4.
  - Then one pixel per cycle; done is 2 cycles after the eof handshake.
- Boundary cases:
  - 1×1 ROI: one pixel with sof=eol=eof=1.
  - roiW==1: eol on every pixel.
  - Full-frame ROI: the last address is IMG_W*IMG_H−1; addresses never wrap.
  - outReady=0 indefinitely: at most 2 outstanding reads plus buffered pixels, so no data loss or overrun.
  - Reset mid-frame: everything returns to reset values next cycle; a readData return in flight is discarded; no done pulse.

Test Plan:
- IMG_W=4, IMG_H=3, ROI (0,0,4,3), outReady=1, mem[a]=a:
  - out 0..11 on consecutive cycles, first outValid 4 cycles after start.
  - sof on 0; eol on 3, 7, 11; eof on 11; done 2 cycles after the pixel-11 handshake.
- ROI (1,1,2,2), same memory: out 5, 6, 9, 10; eol on 6 and 10; eof on 10; readAddr sequence 5, 6, 9, 10.
- Full frame with outReady toggled by a random pattern (~50%):
  - output sequence 0..11 intact, no duplicates or drops.
  - outData stable while outValid&&!outReady; never more than 2 in flight plus buffered.
- ROI (3,0,2,1) and separately roiH=0: err pulses 1 cycle, readEnable never asserted, busy drops after 2 cycles, no done.
- Reset asserted after pixel 5 of a full frame:
  - next cycle: busy=0, outValid=0, readEnable=0.
  - a new start then yields 0..11 cleanly with sof on 0.
- start held high across a whole readout: start ignored while busy; a second readout begins immediately after done with the ROI sampled then.
- 1×1 ROI (2,1): single pixel value 6 with sof=eol=eof=1.
